// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One bit per cycle: shift-add for MULT/MULTU, restoring shift-subtract for DIV/DIVU.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] a_orig;

  logic             accept;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ok;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               b_zero;

  assign busy   = (state != S_IDLE);
  assign accept = (state == S_IDLE) && start && !cancel;

  // Signed ops run on magnitudes; the signs are reapplied in FIX.
  assign sign_a = op[0] & a[WIDTH-1];
  assign sign_b = op[0] & b[WIDTH-1];
  assign abs_a  = sign_a ? (~a + ONE) : a;
  assign abs_b  = sign_b ? (~b + ONE) : b;

  // Multiply step: {acc, shreg} is the running product, multiplier bits leave from shreg[0].
  assign mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});

  // Divide step: acc is the partial remainder, dividend bits leave from shreg's MSB,
  // quotient bits enter at shreg's LSB.
  assign div_shift = {acc, shreg[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, mag_b});
  assign div_sub   = div_shift[WIDTH-1:0] - mag_b;

  assign prod     = {acc, shreg};
  assign prod_fix = neg_q ? (~prod + ONE2) : prod;
  assign quo_fix  = neg_q ? (~shreg + ONE) : shreg;
  assign rem_fix  = neg_r ? (~acc + ONE) : acc;
  assign b_zero   = (mag_b == {WIDTH{1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      acc         <= '0;
      shreg       <= '0;
      mag_b       <= '0;
      a_orig      <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (accept) begin
            state       <= S_RUN;
            count       <= '0;
            is_div      <= op[1];
            neg_q       <= sign_a ^ sign_b;
            neg_r       <= sign_a;
            acc         <= '0;
            shreg       <= abs_a;
            mag_b       <= abs_b;
            a_orig      <= a;
            div_by_zero <= 1'b0;
          end
        end
        S_RUN: begin
          if (cancel) begin
            state <= S_IDLE;
            count <= '0;
          end else begin
            if (is_div) begin
              acc   <= div_ok ? div_sub : div_shift[WIDTH-1:0];
              shreg <= {shreg[WIDTH-2:0], div_ok};
            end else begin
              acc   <= mul_sum[WIDTH:1];
              shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
            end
            if (count == LAST) begin
              state <= S_FIX;
              count <= '0;
            end else begin
              count <= count + CNT_ONE;
            end
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!cancel) begin
            done <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (b_zero) begin
              hi          <= a_orig;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): vector table plus corner-case sequences.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns the number of edges until done is seen, and whether busy dropped early.
  task automatic wait_done(output int cyc, output logic busy_gap);
    cyc      = 0;
    busy_gap = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (!busy) busy_gap = 1'b1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL timeout: done not seen within 200 cycles, got 0 required 1");
    end
  endtask

  task automatic watch_no_done(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  int   cyc;
  logic gap;

  initial begin
    vecs[0]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
    vecs[3]  = '{2'b10, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[6]  = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[7]  = '{2'b01, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
    vecs[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[11] = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[12] = '{2'b00, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};

    rst_n  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    a      = '0;
    b      = '0;
    cancel = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    wdata  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_start", i), 32'(busy), 32'd1);
      wait_done(cyc, gap);
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b latency=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, div_by_zero, cyc);
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'd33);
      check($sformatf("v%0d_busy_gap", i), 32'(gap), 32'd0);
      check($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Back-to-back issue in the done cycle.
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc, gap);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd3;
    b     = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    wait_done(cyc, gap);
    $display("b2b MULTU 3*4 -> hi=%h lo=%h latency=%0d", hi, lo, cyc);
    check("b2b_latency", 32'(cyc), 32'd33);
    check("b2b_lo", lo, 32'd12);
    check("b2b_hi", hi, 32'd0);

    // Start while busy is dropped, not queued.
    issue(2'b10, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd2;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, gap);
    $display("ignored-start DIVU 100/7 -> hi=%h lo=%h latency=%0d", hi, lo, cyc);
    check("ign_latency", 32'(cyc), 32'd27);
    check("ign_hi", hi, 32'd2);
    check("ign_lo", lo, 32'd14);
    @(posedge clk);
    #1;
    check("ign_not_queued", 32'(busy), 32'd0);

    // Cancel ten cycles into a DIV.
    issue(2'b11, 32'hFFFFFFF9, 32'd2);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    $display("cancel DIV at cycle 10 -> busy=%0b hi=%h lo=%h", busy, hi, lo);
    check("cancel_busy", 32'(busy), 32'd0);
    watch_no_done("cancel_no_done", 40);
    check("cancel_hi", hi, 32'd2);
    check("cancel_lo", lo, 32'd14);

    // cancel and start together: cancel wins.
    @(negedge clk);
    start  = 1'b1;
    cancel = 1'b1;
    op     = 2'b00;
    a      = 32'd9;
    b      = 32'd9;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    $display("start+cancel -> busy=%0b", busy);
    check("startcancel_busy", 32'(busy), 32'd0);

    // lo_we while busy is ignored; while idle it writes.
    issue(2'b00, 32'd2, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    lo_we = 1'b1;
    wdata = 32'h12345678;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("lowe_busy_ignored", lo, 32'd14);
    wait_done(cyc, gap);
    $display("MULTU 2*3 with busy lo_we -> hi=%h lo=%h latency=%0d", hi, lo, cyc);
    check("lowe_latency", 32'(cyc), 32'd29);
    check("lowe_result_lo", lo, 32'd6);
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h12345678;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    $display("idle lo_we -> hi=%h lo=%h", hi, lo);
    check("lowe_idle_lo", lo, 32'h12345678);
    check("lowe_idle_hi", hi, 32'd0);

    // hi_we together with an accepted start takes effect, then the result overwrites it.
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hAAAA5555;
    start = 1'b1;
    op    = 2'b00;
    a     = 32'hFFFFFFFF;
    b     = 32'd2;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    start = 1'b0;
    check("hiwe_start_hi", hi, 32'hAAAA5555);
    check("hiwe_start_busy", 32'(busy), 32'd1);
    wait_done(cyc, gap);
    $display("MULTU FFFFFFFF*2 after hi_we -> hi=%h lo=%h latency=%0d", hi, lo, cyc);
    check("hiwe_latency", 32'(cyc), 32'd33);
    check("hiwe_result_hi", hi, 32'd1);
    check("hiwe_result_lo", lo, 32'hFFFFFFFE);

    // Asynchronous reset mid-MULT.
    issue(2'b01, 32'd5, 32'd6);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-MULT -> busy=%0b hi=%h lo=%h", busy, hi, lo);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_dbz", 32'(div_by_zero), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("arst_no_done", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
